// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
package stopwatch_pkg;

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_ADJUST = 1'b1
  } mode_t;

  localparam logic [3:0] BCD_MAX_UNIT = 4'd9;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  function automatic bcd2_t to_bcd2(input int unsigned v);
    bcd2_t r;
    r.tens  = 4'(v / 10);
    r.units = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control inputs and BCD outputs of the stopwatch core, shared with the display controller.
interface stopwatch_counter_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pause_pulse;
  logic       clear_pulse;
  logic       sel;
  logic       adjust;
  logic [3:0] minutes_tens;
  logic [3:0] minutes_units;
  logic [3:0] seconds_tens;
  logic [3:0] seconds_units;
  logic       running;

  modport master (
    output tick_1hz, tick_2hz, pause_pulse, clear_pulse, sel, adjust,
    input  minutes_tens, minutes_units, seconds_tens, seconds_units, running
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause_pulse, clear_pulse, sel, adjust,
    output minutes_tens, minutes_units, seconds_tens, seconds_units, running
  );
endinterface

// File: rtl/stopwatch_counter_bcd_field_counter.sv
// Two-digit BCD counter 00..MAX with synchronous clear priority and a wrap flag.
module bcd_field_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  clear,
  input  logic  inc,
  output bcd2_t value,
  output logic  wrap
);

  localparam bcd2_t MAX_BCD = to_bcd2(MAX);

  logic  at_max;
  bcd2_t value_next;

  assign at_max = (value == MAX_BCD);
  assign wrap   = inc & at_max;

  always_comb begin
    value_next = value;
    if (clear) begin
      value_next = '0;
    end else if (inc) begin
      if (at_max) begin
        value_next = '0;
      end else if (value.units == BCD_MAX_UNIT) begin
        value_next.units = '0;
        value_next.tens  = value.tens + 4'd1;
      end else begin
        value_next.units = value.units + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value <= '0;
    else          value <= value_next;
  end

  digits_legal: assert property (@(posedge clk) disable iff (!reset_n)
    (value.units <= BCD_MAX_UNIT) && (value.tens <= MAX_BCD.tens));

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: 1 Hz counting in NORMAL mode, per-field 2 Hz adjust in ADJUST mode.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_MAX       = 59,
  parameter int unsigned SEC_MAX       = 59,
  parameter bit          START_RUNNING = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  stopwatch_counter_if.slave  bus
);

  mode_t mode, mode_next;
  logic  run_flag;
  logic  sec_inc, min_inc;
  logic  sec_wrap, min_wrap;
  bcd2_t sec_val, min_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mode <= MODE_NORMAL;
    else          mode <= mode_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             run_flag <= START_RUNNING;
    else if (bus.pause_pulse) run_flag <= ~run_flag;
  end

  // Seconds carry feeds minutes only while counting; adjust never carries across fields.
  always_comb begin
    mode_next = mode;
    sec_inc   = 1'b0;
    min_inc   = 1'b0;
    case (mode)
      MODE_NORMAL: begin
        if (bus.adjust) mode_next = MODE_ADJUST;
        sec_inc = run_flag & bus.tick_1hz;
        min_inc = sec_wrap;
      end
      MODE_ADJUST: begin
        if (!bus.adjust) mode_next = MODE_NORMAL;
        sec_inc = bus.tick_2hz & bus.sel;
        min_inc = bus.tick_2hz & ~bus.sel;
      end
      default: mode_next = MODE_NORMAL;
    endcase
  end

  bcd_field_counter #(.MAX(SEC_MAX)) u_seconds (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.clear_pulse),
    .inc     (sec_inc),
    .value   (sec_val),
    .wrap    (sec_wrap)
  );

  bcd_field_counter #(.MAX(MIN_MAX)) u_minutes (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.clear_pulse),
    .inc     (min_inc),
    .value   (min_val),
    .wrap    (min_wrap)
  );

  assign bus.seconds_tens  = sec_val.tens;
  assign bus.seconds_units = sec_val.units;
  assign bus.minutes_tens  = min_val.tens;
  assign bus.minutes_units = min_val.units;
  assign bus.running       = run_flag & (mode == MODE_NORMAL);

  minutes_wrap_needs_carry: assert property (@(posedge clk) disable iff (!reset_n)
    (min_wrap && (mode == MODE_NORMAL)) |-> sec_wrap);

endmodule
